// File: rtl/rr_request_arbiter.sv
// rtl/rr_request_arbiter.sv - 16-way round-robin arbiter with registered one-hot grant and hold limit
//
// Purpose: shares one resource among 16 requesters. A winner is chosen in
// round-robin order starting at ptr. The grant is held until the owner drops its
// request, enable drops, or the hold limit expires. Every grant is followed by at
// least one idle cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       low = no new grants, current grant released
//   req[15:0]    request vector, bit i = requester i
//   grant[15:0]  registered one-hot grant, zero when idle
//   grant_idx    binary index of the grant owner, zero when idle
//   grant_valid  high while grant != 0
//   preempt      one-cycle pulse when the hold limit revokes a grant

module rr_request_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [3:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              found;
  logic [3:0]        winner;
  logic [3:0]        cand;
  logic              owner_req;
  logic              at_limit;
  logic              release_now;

  // First set request bit in order ptr, ptr+1, ... wrapping through 15 to 0.
  always_comb begin
    found  = 1'b0;
    winner = 4'd0;
    cand   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // When MAX_HOLD equals 2**HOLD_W the truncated limit is 0; the counter wraps
  // to 0 on exactly the MAX_HOLD-th cycle, so the compare still fires on time.
  assign owner_req   = req[grant_idx];
  assign at_limit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
  assign release_now = !owner_req || !enable || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      hold_cnt    <= '0;
      grant       <= 16'd0;
      grant_idx   <= 4'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && found) begin
            grant       <= 16'd1 << winner;
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= HOLD_W'(1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            grant       <= 16'd0;
            grant_idx   <= 4'd0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 4'd1;
            hold_cnt    <= '0;
            state       <= IDLE;
            // Only a pure hold-limit revocation counts as a preemption.
            preempt     <= at_limit && owner_req && enable;
          end else if (!(MAX_HOLD == 0 && hold_cnt == '1)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_request_arbiter.sv
// tb/tb_rr_request_arbiter.sv - self-checking bench for rr_request_arbiter

module tb_rr_request_arbiter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic [15:0] grant,  grant0;
  logic [3:0]  grant_idx, grant_idx0;
  logic        grant_valid, grant_valid0;
  logic        preempt, preempt0;

  rr_request_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
  );

  rr_request_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .grant(grant0), .grant_idx(grant_idx0), .grant_valid(grant_valid0), .preempt(preempt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [15:0] rq;
    logic        v;
    logic [3:0]  idx;
    logic        pre;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  idx;
    logic        pre;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t sb0[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input bit alt);
    exp_t e;
    if ((alt ? sb0.size() : sb.size()) == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = alt ? sb0.pop_front() : sb.pop_front();
    if (alt) begin
      cmp("grant0",       32'(grant0),       e.v ? 32'(16'd1 << e.idx) : 32'd0);
      cmp("grant_idx0",   32'(grant_idx0),   32'(e.v ? e.idx : 4'd0));
      cmp("grant_valid0", 32'(grant_valid0), 32'(e.v));
      cmp("preempt0",     32'(preempt0),     32'(e.pre));
    end else begin
      cmp("grant",       32'(grant),       e.v ? 32'(16'd1 << e.idx) : 32'd0);
      cmp("grant_idx",   32'(grant_idx),   32'(e.v ? e.idx : 4'd0));
      cmp("grant_valid", 32'(grant_valid), 32'(e.v));
      cmp("preempt",     32'(preempt),     32'(e.pre));
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, check after the edge.
  task automatic step(input bit alt, input logic en, input logic [15:0] rq,
                      input logic v, input logic [3:0] idx, input logic pre);
    exp_t e;
    enable = en;
    req    = rq;
    e.v = v; e.idx = idx; e.pre = pre;
    if (alt) sb0.push_back(e);
    else     sb.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(alt);
  endtask

  // Asynchronous reset: outputs must clear with no clock edge in between.
  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    #2;
    cmp("rst_grant",        32'(grant),        32'd0);
    cmp("rst_grant_idx",    32'(grant_idx),    32'd0);
    cmp("rst_grant_valid",  32'(grant_valid),  32'd0);
    cmp("rst_preempt",      32'(preempt),      32'd0);
    cmp("rst_grant0",       32'(grant0),       32'd0);
    #2;
    rst_n = 1'b1;
    req   = 16'd0;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic en, input logic [15:0] rq,
                              input logic v, input logic [3:0] idx, input logic pre);
    vec_t t;
    t.en = en; t.rq = rq; t.v = v; t.idx = idx; t.pre = pre;
    vecs.push_back(t);
  endfunction

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 16'd0;

    // Single-owner hold/release, ptr advance, wrap, limit revocation, enable drop,
    // coincident limit+release and re-grant of the same owner after an idle cycle.
    add(1, 16'h0020, 1, 5,  0);
    add(1, 16'h0020, 1, 5,  0);
    add(1, 16'h0020, 1, 5,  0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h0041, 1, 6,  0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h2000, 1, 13, 0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h0009, 1, 0,  0);
    add(1, 16'h0009, 1, 0,  0);
    add(1, 16'h0009, 1, 0,  0);
    add(1, 16'h0009, 1, 0,  0);
    add(1, 16'h0009, 0, 0,  1);
    add(1, 16'h0009, 1, 3,  0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h0080, 1, 7,  0);
    add(0, 16'h0080, 0, 0,  0);
    add(0, 16'hFFFF, 0, 0,  0);
    add(0, 16'hFFFF, 0, 0,  0);
    add(1, 16'h0181, 1, 8,  0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0000, 0, 0,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0002, 0, 0,  1);
    add(1, 16'h0002, 1, 1,  0);
    add(1, 16'h0000, 0, 0,  0);

    do_reset();

    // Mid-grant asynchronous reset with all requests high.
    step(0, 1, 16'hFFFF, 1, 0, 0);
    step(0, 1, 16'hFFFF, 1, 0, 0);
    do_reset();

    foreach (vecs[k]) step(0, vecs[k].en, vecs[k].rq, vecs[k].v, vecs[k].idx, vecs[k].pre);

    // Full rotation under constant requests with MAX_HOLD=4.
    do_reset();
    for (int o = 0; o < 16; o++) begin
      for (int c = 0; c < 4; c++) step(0, 1, 16'hFFFF, 1, 4'(o), 0);
      step(0, 1, 16'hFFFF, 0, 0, 1);
    end
    step(0, 1, 16'hFFFF, 1, 0, 0);

    // Unlimited hold: owner 8 keeps the grant, counter saturates.
    do_reset();
    for (int c = 0; c < 40; c++) step(1, 1, 16'h0100, 1, 8, 0);
    cmp("hold_cnt_sat", 32'(u_dut0.hold_cnt), 32'd15);
    step(1, 1, 16'h0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
